strait_tile_sequencer: RTL
==========================

# strait_tile_sequencer

Normal-mode inference sequencer for the STRAIT accelerator. It runs one or more weight-stationary tiles through the systolic datapath once BIST/BISR has finished. For each tile it handshakes weight rows from the host into the BISR weight allocator, streams activation-memory reads, waits out array drain, and issues accumulator write addresses. It sits beside `hybrid_bist` and drives the same datapath ports only while `test_mode` is low.

## Interface
- `SYSTOLIC_SIZE`, 8, array dimension N; rows loaded, activations streamed and accumulator words written per tile.
- `ADDR_WIDTH`, `$clog2(SYSTOLIC_SIZE)`, row/address width.
- `TILE_CNT_WIDTH`, 8, width of tile count and tile index.
- `DRAIN_CYCLES`, `2*SYSTOLIC_SIZE`, fixed wait between the last activation read and the first accumulator write (D, must be ≥1).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `test_mode` in 1: high means BIST owns the datapath; the sequencer idles or aborts.
- `start` in 1: single-cycle request to run a job.
- `num_tiles` in `TILE_CNT_WIDTH`: tile count T, sampled with `start`.
- `recovery_done` in 1: from BISR.
- `recovery_success` in 1: from BISR.
- `weight_ack` in 1: host presents a valid weight row this cycle.
- `weight_req` out 1: sequencer is ready to take weight rows.
- `weight_valid` out 1: `weight_req & weight_ack` (combinational), routed to BISR.
- `weight_row_addr` out `ADDR_WIDTH`: index of the row being loaded.
- `act_rd_en` out 1: activation-memory read strobe.
- `act_rd_addr` out `ADDR_WIDTH`: activation read address.
- `acc_wr_en` out 1: accumulator write strobe.
- `acc_wr_addr` out `ADDR_WIDTH`: accumulator write address.
- `tile_idx` out `TILE_CNT_WIDTH`: index of the current tile.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the job completes.
- `reject` out 1: one-cycle pulse when `start` is refused.
- `aborted` out 1: one-cycle pulse when `test_mode` kills a running job.
- `cycle_count` out 32: busy-cycle counter (see Configuration).

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, WRITE, NEXT.
- **IDLE, start accepted:** accepted only if `start & ~test_mode & recovery_done & recovery_success`.
  - Latches `num_tiles`, clears `tile_idx` and all counters.
  - If T=0: `done` pulses the next cycle and the state stays IDLE.
  - Otherwise the state goes to LOAD_W.
- **IDLE, start refused:** `start` while `test_mode=1`, `recovery_done=0` or `recovery_success=0` pulses `reject` the next cycle. State stays IDLE.
- **LOAD_W:**
  - `weight_req=1`.
  - Each cycle with `weight_ack=1`, `weight_row_addr` increments.
  - `weight_ack=0` stalls with no timeout.
  - After the N-th ack (address N-1) the state goes to STREAM.
- **STREAM:** `act_rd_en=1` for exactly N cycles with `act_rd_addr` 0..N-1, then DRAIN.
- **DRAIN:** all strobes low for exactly D cycles, then WRITE.
- **WRITE:** `acc_wr_en=1` for exactly N cycles with `acc_wr_addr` 0..N-1, then NEXT.
- **NEXT:** one cycle.
  - If `tile_idx == T-1`: go to IDLE and pulse `done`.
  - Otherwise: increment `tile_idx` and go to LOAD_W.
- **Abort:** `test_mode` sampled high in any non-IDLE state.
  - Next cycle: state IDLE, all strobes low, `aborted` pulses, no `done`.
- **Counter wrap:** address counters wrap to 0 when leaving each state. `tile_idx` never wraps; T ≤ 2^TILE_CNT_WIDTH−1.
- **`start` while busy:** ignored, no `reject`.

## Timing
- **Reset values:** every output 0; state IDLE.
- **Registered outputs:** all outputs except `weight_valid` are registered. Each state's strobes are valid from its first cycle.
- **Cycle numbering:** acceptance edge = cycle 0. With `weight_ack` held high:
  - LOAD_W: cycles 1..N
  - STREAM: N+1..2N
  - DRAIN: 2N+1..2N+D
  - WRITE: 2N+D+1..3N+D
  - NEXT: 3N+D+1
- **Per-tile length:** 3N+D+1 cycles without stalls, plus any `weight_ack`-low cycles.
- **Job completion:** `done` is high in cycle T·(3N+D+1)+1. `busy` is low in that same cycle.
- **Reject timing:** `reject`, and `done` for T=0, appear in cycle 1.
- **Simultaneous events:** `test_mode` and NEXT-of-last-tile in the same cycle resolve as abort (no `done`).
- **Reset mid-operation:** asynchronous `rst` clears everything immediately. No pulse is generated.

## Configuration
- **`STRAIT_SEQ_PERF_CNT_EN` defined:**
  - `cycle_count` clears on accepted `start`.
  - It then increments each cycle `busy=1`, saturating at 2^32−1.
  - It holds its value after `done` or `aborted`.
- **Not defined:** `cycle_count` is tied to 0 and no counter flops are synthesized.

## Test plan
- N=8, D=16, T=1, `weight_ack` held high, start → `act_rd_en` in cycles 9–16, `acc_wr_en` in cycles 33–40 with addresses 0–7, `done` in cycle 42, `cycle_count`=41 (macro on).
- T=3, `weight_ack` low for 5 cycles during tile 1 → `tile_idx` steps 0,1,2, `done` in cycle 3·41+5+1=129.
- `recovery_success=0`, start → `reject` in cycle 1, `busy` stays 0. Separately, T=0 → `done` in cycle 1.
- Raise `test_mode` in cycle 20 of a T=2 job → `aborted` in cycle 21, all strobes 0, no `done`. A later start with `test_mode=0` runs normally.
- Assert `rst` during WRITE → all outputs 0 immediately, state IDLE. `start` pulsed in the WRITE state with `rst` low → ignored.
- Macro off → `cycle_count`=0 throughout the first scenario.

Source files
------------

// File: rtl/strait_tile_sequencer.sv
// strait_tile_sequencer: normal-mode inference sequencer for the STRAIT array.
// Per tile: load N weight rows (host handshake), stream N activation reads,
// wait DRAIN_CYCLES for the array to empty, then write N accumulator words.
// Optional feature macro: STRAIT_SEQ_PERF_CNT_EN enables the busy-cycle counter
// on cycle_count; without it cycle_count is constant zero.
module strait_tile_sequencer #(
    parameter int SYSTOLIC_SIZE  = 8,
    parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
    parameter int TILE_CNT_WIDTH = 8,
    parameter int DRAIN_CYCLES   = 2 * SYSTOLIC_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      test_mode,
    input  logic                      start,
    input  logic [TILE_CNT_WIDTH-1:0] num_tiles,
    input  logic                      recovery_done,
    input  logic                      recovery_success,
    input  logic                      weight_ack,
    output logic                      weight_req,
    output logic                      weight_valid,
    output logic [ADDR_WIDTH-1:0]     weight_row_addr,
    output logic                      act_rd_en,
    output logic [ADDR_WIDTH-1:0]     act_rd_addr,
    output logic                      acc_wr_en,
    output logic [ADDR_WIDTH-1:0]     acc_wr_addr,
    output logic [TILE_CNT_WIDTH-1:0] tile_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      reject,
    output logic                      aborted,
    output logic [31:0]               cycle_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR  = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [DRAIN_W-1:0]        LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0]        DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [TILE_CNT_WIDTH-1:0] TILE_ONE   = TILE_CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_WRITE, S_NEXT
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
    logic [DRAIN_W-1:0]        drain_q, drain_d;
    logic [TILE_CNT_WIDTH-1:0] tile_q, tile_d;
    logic [TILE_CNT_WIDTH-1:0] ntiles_q, ntiles_d;
    logic                      done_d, reject_d, aborted_d;
    logic                      start_ok;

    logic                      weight_req_q, act_rd_en_q, acc_wr_en_q, busy_q;
    logic [ADDR_WIDTH-1:0]     row_addr_q, act_addr_q, acc_addr_q;
    logic                      done_q, reject_q, aborted_q;

    assign start_ok = (state_q == S_IDLE) & start & ~test_mode
                      & recovery_done & recovery_success;

    // Next-state logic: abort takes priority over every normal transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        tile_d    = tile_q;
        ntiles_d  = ntiles_q;
        done_d    = 1'b0;
        reject_d  = 1'b0;
        aborted_d = 1'b0;
        if (state_q != S_IDLE && test_mode) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            drain_d   = '0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        ntiles_d = num_tiles;
                        tile_d   = '0;
                        cnt_d    = '0;
                        drain_d  = '0;
                        if (num_tiles == '0) done_d = 1'b1;
                        else                 state_d = S_LOAD_W;
                    end else if (start) begin
                        reject_d = 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (weight_ack) begin
                        if (cnt_q == LAST_ADDR) begin
                            cnt_d   = '0;
                            state_d = S_STREAM;
                        end else begin
                            cnt_d = cnt_q + ADDR_ONE;
                        end
                    end
                end
                S_STREAM: begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        drain_d = '0;
                        state_d = S_WRITE;
                    end else begin
                        drain_d = drain_q + DRAIN_ONE;
                    end
                end
                S_WRITE: begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = S_NEXT;
                    end else begin
                        cnt_d = cnt_q + ADDR_ONE;
                    end
                end
                S_NEXT: begin
                    if (tile_q == ntiles_q - TILE_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tile_d  = tile_q + TILE_ONE;
                        state_d = S_LOAD_W;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and outputs; outputs are registered from next-state so
    // each state's strobes are valid from its first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            drain_q      <= '0;
            tile_q       <= '0;
            ntiles_q     <= '0;
            weight_req_q <= 1'b0;
            act_rd_en_q  <= 1'b0;
            acc_wr_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            row_addr_q   <= '0;
            act_addr_q   <= '0;
            acc_addr_q   <= '0;
            done_q       <= 1'b0;
            reject_q     <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            tile_q       <= tile_d;
            ntiles_q     <= ntiles_d;
            weight_req_q <= (state_d == S_LOAD_W);
            act_rd_en_q  <= (state_d == S_STREAM);
            acc_wr_en_q  <= (state_d == S_WRITE);
            busy_q       <= (state_d != S_IDLE);
            row_addr_q   <= (state_d == S_LOAD_W) ? cnt_d : '0;
            act_addr_q   <= (state_d == S_STREAM) ? cnt_d : '0;
            acc_addr_q   <= (state_d == S_WRITE)  ? cnt_d : '0;
            done_q       <= done_d;
            reject_q     <= reject_d;
            aborted_q    <= aborted_d;
        end
    end

`ifdef STRAIT_SEQ_PERF_CNT_EN
    logic [31:0] cyc_q;

    // Busy-cycle counter: cleared on accepted start, saturates, holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            cyc_q <= '0;
        else if (start_ok)                  cyc_q <= '0;
        else if (busy_q && (cyc_q != '1))   cyc_q <= cyc_q + 32'd1;
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

    assign weight_req      = weight_req_q;
    assign weight_valid    = weight_req_q & weight_ack;
    assign weight_row_addr = row_addr_q;
    assign act_rd_en       = act_rd_en_q;
    assign act_rd_addr     = act_addr_q;
    assign acc_wr_en       = acc_wr_en_q;
    assign acc_wr_addr     = acc_addr_q;
    assign tile_idx        = tile_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign reject          = reject_q;
    assign aborted         = aborted_q;

endmodule
